// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
//   state_t   : sequencer states (BOOT, RUN, HALTED, FAULT)
//   INSTR_W   : instruction word width
//   PC_STEP   : byte increment between sequential instructions
//   NOP_INSTR : value held in the fetch register while nothing was fetched
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_range_check.sv
// fetch_range_check: combinational alignment and bounds check of a fetch PC.
// Only instantiated when IFETCH_CHECK_EN is defined.
// Ports:
//   i_pc   in  32  byte address about to be fetched
//   o_bad  out 1   address is misaligned or beyond the instruction memory
module fetch_range_check #(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic [31:0] i_pc,
  output logic        o_bad
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (i_pc[1:0] != 2'b00);
  assign w_out_of_range = (i_pc[31:2] >= WORD_LIMIT);
  assign o_bad          = w_misaligned | w_out_of_range;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer and fetch controller for a word-addressed,
// combinationally read instruction memory. Holds the PC, registers the
// returned word into a fetch register, and hands it to decode.
//
// Handshake: if_valid/if_ready. A transfer completes on any rising edge
// where if_valid && if_ready. if_valid, if_instr, if_pc and if_pc_plus4
// stay stable while if_valid && !if_ready, unless a redirect discards the
// word. Every completed transfer increments fetch_count.
//
// Configuration macro: IFETCH_CHECK_EN enables the alignment/bounds check
// and the sticky FAULT state. Without it, fault is tied low and addresses
// alias into the memory by truncation.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_addr   out 32    byte address to instruction memory (the PC register)
//   imem_data   in  32    instruction word for imem_addr, same cycle
//   redirect_valid/_pc    branch/jump redirect, highest priority
//   halt_req    in  1     level request to stop fetching
//   if_valid/if_ready     fetch-to-decode handshake
//   if_instr, if_pc, if_pc_plus4  fetched word and its addresses
//   halted      out 1     sequencer is in HALTED
//   fault       out 1     sticky fetch fault
//   fetch_count out 32    completed handshakes, wraps
//   dbg_state   out 2     current FSM state (fetch_pkg::state_t encoding)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fetch_count,
  output logic [1:0]         dbg_state
);

  if (MEM_WORDS < 1 || MEM_WORDS > (1 << 30)) begin : g_bad_mem_words
    $error("fetch_sequencer: MEM_WORDS out of range");
  end

  state_t             r_state;
  logic [31:0]        r_pc;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [31:0]        r_if_pc;
  logic [31:0]        r_if_pc_plus4;
  logic               r_halted;
  logic               r_fault;
  logic [31:0]        r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic        w_handshake;
  logic        w_slot_free;
  logic        w_pc_bad;

  assign w_pc_plus4  = r_pc + PC_STEP;
  assign w_handshake = r_if_valid & if_ready;
  // The fetch register can take a new word if it is empty or being drained.
  assign w_slot_free = ~r_if_valid | if_ready;

`ifdef IFETCH_CHECK_EN
  fetch_range_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_range_check (
    .i_pc  (r_pc),
    .o_bad (w_pc_bad)
  );
`else
  assign w_pc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      // Counting is independent of state: any completed transfer counts,
      // including one in the same cycle as a redirect or halt.
      if (w_handshake) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
            r_state    <= halt_req ? ST_HALTED : ST_RUN;
            r_halted   <= halt_req;
          end else if (halt_req) begin
            // No new load; a pending word stays until decode takes it.
            if (w_handshake) begin
              r_if_valid <= 1'b0;
            end
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (w_slot_free) begin
            if (w_pc_bad) begin
              // pc is left on the faulting address for inspection.
              r_state    <= ST_FAULT;
              r_fault    <= 1'b1;
              r_if_valid <= 1'b0;
            end else begin
              r_if_instr    <= imem_data;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_plus4;
              r_if_valid    <= 1'b1;
              r_pc          <= w_pc_plus4;
            end
          end
        end

        ST_HALTED: begin
          if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
          end else if (w_handshake) begin
            r_if_valid <= 1'b0;
          end
          // Leaving HALTED only changes state; the next RUN cycle fetches
          // from the held pc.
          if (!halt_req) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end

        ST_FAULT: begin
          // Sticky until reset; redirect and halt are ignored.
          r_if_valid <= 1'b0;
        end

        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign halted      = r_halted;
`ifdef IFETCH_CHECK_EN
  assign fault       = r_fault;
`else
  assign fault       = 1'b0;
`endif
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer and fetch controller for the MIPS core's word-addressed instruction memory (combinational read, 8192 x 32). It holds the PC, drives the memory address, registers the returned word into a fetch output register, and hands instructions to decode over a valid/ready handshake. It also applies branch/jump redirects and halt requests, and keeps a count of delivered instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- MEM_WORDS, 8192, instruction memory depth in words (range check only)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to instruction memory (= PC register)
- imem_data  in  32  instruction word, valid combinationally in the same cycle as imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target byte address
- halt_req  in  1  level request to stop fetching
- if_valid  out  1  fetch register holds an instruction
- if_ready  in  1  decode accepts the instruction this cycle
- if_instr  out  32  fetched instruction
- if_pc  out  32  byte address of if_instr
- if_pc_plus4  out  32  if_pc + 4, for link/branch computation
- halted  out  1  sequencer is in HALTED
- fault  out  1  sticky fetch fault (only with IFETCH_CHECK_EN)
- fetch_count  out  32  count of completed handshakes, wraps modulo 2^32

## Operation
- States: BOOT, RUN, HALTED, FAULT.
- BOOT: entered on reset. Goes to RUN on the next edge. No fetch is performed.
- RUN, load condition: a load happens when (!if_valid || if_ready) and there is no redirect. The load does:
  - if_instr <= imem_data
  - if_pc <= pc
  - if_pc_plus4 <= pc+4
  - if_valid <= 1
  - pc <= pc+4
- RUN, back-pressure: if if_valid && !if_ready, all fetch registers and the pc hold.
- Handshake: completes when if_valid && if_ready. Each completed handshake increments fetch_count, in every state.
- Redirect (RUN or HALTED): highest priority.
  - pc <= redirect_pc
  - if_valid <= 0 next cycle, discarding any unaccepted word
  - A handshake in the same cycle still completes and counts.
- halt_req in RUN:
  - pc and if_* hold, and no new load happens.
  - If if_valid is set, it drops after that word is accepted.
  - The state moves to HALTED at the first edge where halt_req=1.
  - redirect + halt_req together: pc <= redirect_pc, if_valid <= 0, next state HALTED.
- HALTED: halted=1. Returns to RUN at the first edge where halt_req=0. Fetch resumes from the held pc.
- PC arithmetic: 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - pc=RESET_PC; state=BOOT
  - if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0
  - halted=0; fault=0; fetch_count=0
- Reset mid-operation: all of the above apply immediately (asynchronous); any pending word is lost.
- Latency:
  - 1st edge after rst_n rises: BOOT to RUN.
  - 2nd edge: if_valid=1 with the word at RESET_PC.
- Throughput: one instruction per cycle while if_ready=1.
- Redirect latency: redirect asserted at edge N means the target word is in if_instr after edge N+1. Exactly one bubble (if_valid=0) appears between them.
- imem_addr is the registered pc, so it has no combinational path from the inputs.

## Configuration
- IFETCH_CHECK_EN defined:
  - Before a load, the pc is checked. The check fails if pc[1:0]!=0 or pc[31:2] >= MEM_WORDS.
  - On a failed check: state goes to FAULT, fault=1, if_valid=0, and pc holds the faulting address.
  - FAULT is left only by reset. Redirect and halt_req are ignored there.
  - A redirect to a bad target faults on the following cycle.
- IFETCH_CHECK_EN undefined:
  - There is no check and no FAULT state, and fault is tied 0.
  - Out-of-range addresses alias into the memory by truncation.

## Structure
- Package fetch_pkg:
  - state enum (BOOT, RUN, HALTED, FAULT)
  - INSTR_W=32
  - PC_STEP=4
  - NOP_INSTR=32'h0000_0000
- Optional sub-module fetch_range_check: a combinational alignment/bounds checker, instantiated only under IFETCH_CHECK_EN.

## Test plan
- Reset release, if_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> after edge 2, if_instr=0x11, if_pc=0. Then one word per cycle; fetch_count=4 after the four handshakes.
- if_ready=0 for 3 cycles while if_valid=1 at if_pc=8 -> if_instr, if_pc and imem_addr=0xC all hold. On release, 0xC is delivered next.
- Redirect to 0x40 while the word at 0x10 is valid and unaccepted -> one bubble, then if_pc=0x40, if_pc_plus4=0x44; fetch_count unchanged by the discarded word.
- halt_req=1 for 4 cycles, then 0 -> halted=1 while the request is held; fetch resumes at the held pc with no skipped or duplicated word. redirect+halt_req together -> resumes at the redirect target.
- With IFETCH_CHECK_EN: redirect to 0x6 -> fault=1, pc=0x6, if_valid=0, and the sequencer stays in FAULT until rst_n. Redirect to 0x8000 (word 8192) -> fault.
- Without IFETCH_CHECK_EN: pc starting at 0xFFFF_FFFC -> next pc is 0; fault stays 0.
